// File: rtl/uart_fmt_pkg.sv
// rtl/uart_fmt_pkg.sv - ASCII constants and state encoding for the matrix printer
package uart_fmt_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    ACK,
    DRAIN
  } state_t;

endpackage

// File: rtl/uart_matrix_printer_if.sv
// rtl/uart_matrix_printer_if.sv - RAM read port and UART TX byte handshake bundle
interface uart_matrix_printer_if #(
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ELEM_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    output rd_en, rd_addr, tx_data, tx_start,
    input  rd_data, tx_busy
  );

  modport slave (
    input  rd_en, rd_addr, tx_data, tx_start,
    output rd_data, tx_busy
  );
endinterface

// File: rtl/uart_matrix_printer_dec_digits.sv
// rtl/uart_matrix_printer_dec_digits.sv - signed value to sign and decimal digits
module dec_digits #(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] value,
  output logic              neg,
  output logic [3:0]        hundreds,
  output logic [3:0]        tens,
  output logic [3:0]        units,
  output logic [1:0]        ndigits
);
  localparam int MW = ELEM_W + 1;

  logic [MW-1:0] mag;
  logic [MW-1:0] rem;

  // Magnitude carries one extra bit so the most negative value stays positive;
  // digits come from a descending compare-subtract chain.
  always_comb begin
    neg      = value[ELEM_W-1];
    mag      = neg ? ({1'b0, ~value} + MW'(1)) : {1'b0, value};
    rem      = mag;
    hundreds = 4'd0;
    tens     = 4'd0;
    for (int i = 2; i >= 1; i--) begin
      if (hundreds == 4'd0 && rem >= MW'(i * 100)) begin
        hundreds = 4'(i);
        rem      = rem - MW'(i * 100);
      end
    end
    for (int i = 9; i >= 1; i--) begin
      if (tens == 4'd0 && rem >= MW'(i * 10)) begin
        tens = 4'(i);
        rem  = rem - MW'(i * 10);
      end
    end
    units   = rem[3:0];
    ndigits = (hundreds != 4'd0) ? 2'd3 : (tens != 4'd0) ? 2'd2 : 2'd1;
  end
endmodule

// File: rtl/uart_matrix_printer.sv
// rtl/uart_matrix_printer.sv - prints a stored matrix as signed decimal text over UART
module uart_matrix_printer
  import uart_fmt_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            rows,
  input  logic [2:0]            cols,
  input  logic [ADDR_W-1:0]     base_addr,
  uart_matrix_printer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam logic [2:0] MAX_D = 3'(MAX_DIM);

  state_t            state, state_n;
  logic [2:0]        rows_q, cols_q, row, col;
  logic [ADDR_W-1:0] base_q, idx;
  logic [7:0]        q   [8];
  logic [7:0]        q_n [8];
  logic [2:0]        qlen, qptr, n_chars;
  logic              done_q, err_q;
  logic              neg;
  logic [3:0]        hund, tens, units;
  logic [1:0]        ndig;
  logic              dims_ok, last_col, last_elem, more_chars;

  dec_digits #(.ELEM_W(ELEM_W)) u_dec (
    .value    (bus.rd_data),
    .neg      (neg),
    .hundreds (hund),
    .tens     (tens),
    .units    (units),
    .ndigits  (ndig)
  );

  assign dims_ok    = (rows != 3'd0) && (rows <= MAX_D) && (cols != 3'd0) && (cols <= MAX_D);
  assign last_col   = (col == cols_q - 3'd1);
  assign last_elem  = last_col && (row == rows_q - 3'd1);
  assign more_chars = (qptr + 3'd1) != qlen;
  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  // qptr only moves on DRAIN exit, so the head stays put across SEND/ACK/DRAIN.
  assign bus.tx_data = q[qptr];

  // Character queue for the element on rd_data: sign, digits, then separator or CR LF.
  always_comb begin
    for (int i = 0; i < 8; i++) q_n[i] = 8'h00;
    n_chars = 3'd0;
    if (neg) begin
      q_n[n_chars] = CH_MINUS;
      n_chars      = n_chars + 3'd1;
    end
    if (ndig == 2'd3) begin
      q_n[n_chars] = CH_ZERO + {4'd0, hund};
      n_chars      = n_chars + 3'd1;
    end
    if (ndig >= 2'd2) begin
      q_n[n_chars] = CH_ZERO + {4'd0, tens};
      n_chars      = n_chars + 3'd1;
    end
    q_n[n_chars] = CH_ZERO + {4'd0, units};
    n_chars      = n_chars + 3'd1;
    if (last_col) begin
      q_n[n_chars]         = CH_CR;
      q_n[n_chars + 3'd1]  = CH_LF;
      n_chars              = n_chars + 3'd2;
    end else begin
      q_n[n_chars] = CH_SPACE;
      n_chars      = n_chars + 3'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_n      = state;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.tx_start = 1'b0;
    case (state)
      IDLE:  if (start && dims_ok) state_n = FETCH;
      FETCH: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = base_q + idx;
        state_n     = LOAD;
      end
      LOAD:  state_n = SEND;
      SEND:  if (!bus.tx_busy) begin
        bus.tx_start = 1'b1;
        state_n      = ACK;
      end
      ACK:   if (bus.tx_busy) state_n = DRAIN;
      DRAIN: if (!bus.tx_busy) begin
        if (more_chars)      state_n = SEND;
        else if (!last_elem) state_n = FETCH;
        else                 state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: dimension latch, element position, character queue and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q <= '0;
      cols_q <= '0;
      base_q <= '0;
      idx    <= '0;
      row    <= '0;
      col    <= '0;
      qlen   <= '0;
      qptr   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < 8; i++) q[i] <= 8'h00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (dims_ok) begin
            rows_q <= rows;
            cols_q <= cols;
            base_q <= base_addr;
            idx    <= '0;
            row    <= '0;
            col    <= '0;
          end else begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        LOAD: begin
          for (int i = 0; i < 8; i++) q[i] <= q_n[i];
          qlen <= n_chars;
          qptr <= '0;
        end
        DRAIN: if (!bus.tx_busy) begin
          if (more_chars) begin
            qptr <= qptr + 3'd1;
          end else if (!last_elem) begin
            idx <= idx + ADDR_W'(1);
            if (last_col) begin
              col <= '0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end else begin
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_matrix_printer.sv
// tb/tb_uart_matrix_printer.sv - directed self-checking bench for uart_matrix_printer
module tb_uart_matrix_printer;
  import uart_fmt_pkg::*;

  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] rows, cols;
  logic [4:0] base_addr;
  logic       busy, done, err;

  logic [7:0]  mem [32];
  logic        uart_busy = 1'b0;
  logic        foreign_busy = 1'b0;
  int          frame_cnt = 0;
  logic [7:0]  captured [$];
  logic [4:0]  addr_log [$];
  logic [7:0]  last_byte = 8'h00;
  int          n_starts = 0, n_rd = 0, bad_starts = 0, unstable = 0;
  int          compared = 0, mismatched = 0;
  int          snap_starts, snap_rd;

  always #5 clk = ~clk;

  uart_matrix_printer_if #(.ELEM_W(8), .ADDR_W(5)) bus ();

  uart_matrix_printer #(.ELEM_W(8), .MAX_DIM(5), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rows      (rows),
    .cols      (cols),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign bus.tx_busy = uart_busy | foreign_busy;

  // Matrix RAM: one-cycle read latency, logs every address read.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data <= mem[bus.rd_addr];
      addr_log.push_back(bus.rd_addr);
      n_rd++;
    end
  end

  // Transmitter model plus protocol monitors.
  always @(posedge clk) begin
    if (bus.tx_start && bus.tx_busy) bad_starts++;
    if (uart_busy && !rst && bus.tx_data !== last_byte) unstable++;
    if (bus.tx_start) begin
      captured.push_back(bus.tx_data);
      last_byte = bus.tx_data;
      n_starts++;
      uart_busy <= 1'b1;
      frame_cnt <= FRAME;
    end else if (uart_busy) begin
      if (frame_cnt == 1) uart_busy <= 1'b0;
      frame_cnt <= frame_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [2:0] r, input logic [2:0] c, input logic [4:0] b);
    rows = r; cols = c; base_addr = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_err_at_done"}, err, 0);
  endtask

  task automatic expect_text(input string tag, input string s);
    check({tag, "_len"}, captured.size(), s.len());
    for (int i = 0; i < s.len() && i < captured.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), captured[i], s[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rows = 3'd0; cols = 3'd0; base_addr = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[5]  = 8'd0;
    mem[10] = 8'd1;   mem[11] = 8'hFE; mem[12] = 8'd127; mem[13] = 8'h80;
    mem[20] = 8'd100; mem[21] = 8'hF6; mem[22] = 8'd5;
    mem[30] = 8'd1;   mem[31] = 8'hFE; mem[0]  = 8'd127; mem[1]  = 8'h80;

    repeat (2) @(negedge clk);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1x1 zero, with first-transaction latency
    captured.delete(); addr_log.delete();
    pulse_start(3'd1, 3'd1, 5'd5);
    check("t1_rd_en", bus.rd_en, 1);
    check("t1_rd_addr", bus.rd_addr, 5);
    check("t1_busy", busy, 1);
    repeat (2) @(negedge clk);
    check("t1_tx_start", bus.tx_start, 1);
    check("t1_tx_data", bus.tx_data, 8'h30);
    wait_done("t1");
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    expect_text("t1", "0\015\012");

    // 2x2 with a second start mid-stream
    captured.delete(); addr_log.delete();
    pulse_start(3'd2, 3'd2, 5'd10);
    repeat (20) @(negedge clk);
    pulse_start(3'd1, 3'd1, 5'd0);
    wait_done("t2");
    expect_text("t2", "1 -2\015\012127 -128\015\012");
    check("t2_naddr", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check($sformatf("t2_addr%0d", i), addr_log[i], 10 + i);

    // 1x3 behind a foreign sender
    captured.delete(); addr_log.delete();
    foreign_busy = 1'b1;
    snap_starts = n_starts;
    pulse_start(3'd1, 3'd3, 5'd20);
    repeat (12) @(negedge clk);
    check("t3_held_off", n_starts, snap_starts);
    check("t3_busy_waiting", busy, 1);
    foreign_busy = 1'b0;
    wait_done("t3");
    expect_text("t3", "100 -10 5\015\012");
    check("t3_no_start_while_busy", bad_starts, 0);
    check("t3_tx_data_stable", unstable, 0);

    // illegal dimensions
    snap_starts = n_starts; snap_rd = n_rd;
    pulse_start(3'd0, 3'd2, 5'd0);
    check("t4a_done", done, 1);
    check("t4a_err", err, 1);
    check("t4a_busy", busy, 0);
    @(negedge clk);
    check("t4a_done_pulse", done, 0);
    check("t4a_err_pulse", err, 0);
    pulse_start(3'd2, 3'd6, 5'd0);
    check("t4b_done", done, 1);
    check("t4b_err", err, 1);
    repeat (5) @(negedge clk);
    check("t4_no_rd_en", n_rd, snap_rd);
    check("t4_no_tx_start", n_starts, snap_starts);

    // reset after third character, then full reprint across address wrap
    captured.delete(); addr_log.delete();
    pulse_start(3'd2, 3'd2, 5'd30);
    for (int n = 0; n < 1000 && captured.size() < 3; n++) @(negedge clk);
    check("t5_third_char", captured.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tx_start", bus.tx_start, 0);
    check("t5_busy", busy, 0);
    check("t5_rd_en", bus.rd_en, 0);
    check("t5_state", dut.state, IDLE);
    rst = 1'b0;
    captured.delete(); addr_log.delete();
    repeat (15) @(negedge clk);
    check("t5_silent", captured.size(), 0);
    pulse_start(3'd2, 3'd2, 5'd30);
    wait_done("t5");
    expect_text("t5", "1 -2\015\012127 -128\015\012");
    check("t5_naddr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("t5_addr0", addr_log[0], 30);
      check("t5_addr1", addr_log[1], 31);
      check("t5_addr2", addr_log[2], 0);
      check("t5_addr3", addr_log[3], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_matrix_printer.md
# uart_matrix_printer

Streams a stored matrix out over UART as human-readable signed decimal ASCII text, one row per line. It sits between the matrix storage RAM and the TX byte interface of the UART transceiver. It reads elements in row-major order, converts each to text and feeds characters to the transmitter one at a time using the tx_start/tx_busy handshake. It signals done when the final line terminator has been fully shifted out.

## Interface
- ELEM_W, 8: element width; elements are two's-complement signed.
- MAX_DIM, 5: largest legal row or column count.
- ADDR_W, 5: matrix RAM address width; must satisfy 2^ADDR_W ≥ MAX_DIM².
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request; rows, cols and base_addr are sampled on this cycle.
- rows  in  3  row count.
- cols  in  3  column count.
- base_addr  in  ADDR_W  RAM address of element (0,0).
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  ELEM_W  RAM read data, valid one cycle after rd_en.
- tx_data  out  8  character to the transmitter.
- tx_start  out  1  single-cycle send request.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start and falls when the stop bit ends.
- busy  out  1  high from an accepted start until done.
- done  out  1  single-cycle completion pulse.
- err  out  1  high together with done when the dimensions are illegal.

## Operation
- Reset values: rd_en=0, rd_addr=0, tx_data=0x00, tx_start=0, busy=0, done=0, err=0. The state machine goes to IDLE.
- Output format:
  - Each element prints as an optional '-' (0x2D), then digits with no leading zeros; zero prints as "0".
  - Elements within a row are separated by a single ' ' (0x20). There is no trailing space.
  - Each row ends with CR LF (0x0D 0x0A), including the last row.
- States:
  - IDLE
    - On start with 1≤rows≤MAX_DIM and 1≤cols≤MAX_DIM, latch the inputs, clear counters and go to FETCH.
    - On start with illegal dimensions, pulse done and err on the next cycle and stay in IDLE. No rd_en and no tx_start are issued.
  - FETCH: rd_en=1 and rd_addr=base_addr+idx for one cycle, then go to LOAD.
  - LOAD: capture rd_data, compute the sign, magnitude and digits, and build the character queue (maximum 6 characters: sign, 3 digits, separator or CR LF). Go to SEND.
  - SEND: requires tx_busy=0. Drive tx_data with the head of the queue and pulse tx_start, then go to ACK.
  - ACK: wait for tx_busy=1, then go to DRAIN.
  - DRAIN: wait for tx_busy=0.
    - If characters remain in the queue, go to SEND.
    - Otherwise, if elements remain, advance idx and col (col wraps to 0 at cols and row increments), then go to FETCH.
    - Otherwise pulse done and go to IDLE.
- tx_data holds its value from the SEND cycle until DRAIN exits.
- Arithmetic:
  - magnitude = |value| in ELEM_W+1 bits, so -128 gives 128.
  - hundreds/tens/units use a compare-subtract chain, not a divider.
  - idx is ADDR_W bits; base_addr+idx wraps modulo 2^ADDR_W.
- Boundary behaviour:
  - start while busy is ignored.
  - If rst is asserted mid-stream, all outputs return to reset values on the next edge. A character already accepted by the transmitter finishes on its own; no further characters follow.
  - If tx_busy is already high in SEND (a foreign sender is active), SEND waits and tx_start is not pulsed.

## Timing
- start to first rd_en: 1 cycle. rd_en to LOAD capture: 1 cycle. LOAD to first tx_start: 1 cycle.
- Each character takes tx_start, then 1 cycle until tx_busy rises, then the transmitter frame time, then 1 cycle before the next tx_start.
- done follows the falling edge of tx_busy for the last LF by 1 cycle. busy drops in the same cycle as done.

## Structure
- Shared package uart_fmt_pkg holds:
  - the ASCII constants: CH_SPACE, CH_MINUS, CH_CR, CH_LF, CH_ZERO;
  - the state enum: IDLE, FETCH, LOAD, SEND, ACK, DRAIN.
- One sub-module, dec_digits: combinational conversion from a signed ELEM_W value to {neg, hundreds, tens, units, ndigits}. It is instantiated once and feeds the LOAD state.

## Test plan
- 1×1 matrix [0] → bytes 0x30 0x0D 0x0A, then done; err=0.
- 2×2 matrix [1, -2; 127, -128] → "1 -2\r\n127 -128\r\n" (16 bytes) in exactly that order. rd_addr sequence base, base+1, base+2, base+3.
- 1×3 matrix [100, -10, 5] → "100 -10 5\r\n". Check that tx_data is stable through each ACK/DRAIN window and that no tx_start is issued while tx_busy=1.
- rows=0 or cols=6 → done and err pulse 1 cycle after start; zero rd_en and zero tx_start.
- start pulsed again mid-stream → ignored, and output is identical to a single run.
- rst asserted after the 3rd character of a 2×2 print → tx_start=0, busy=0 and state IDLE on the next edge. A following start with valid dimensions prints the full matrix from the beginning.
